// File: rtl/digit_serial_addsub_pkg.sv
// Shared constants for the digit-serial add/sub sequencer.
// State encodings, digit width and counter sizing helper.
package digit_serial_addsub_pkg;

   localparam int DIGIT_W = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Enough bits to count WIDTH/2 digits, with one spare for WIDTH=2.
   function automatic int cnt_width(input int width);
      return $clog2(width / DIGIT_W) + 1;
   endfunction

endpackage

// File: rtl/digit_serial_addsub_slice.sv
// Two-bit ripple add slice used as the digit datapath.
// Optional B inversion via sub_i; carry in and out of both bits.
module twoBitAdder (
   input  logic [1:0] a_i,
   input  logic [1:0] b_i,
   input  logic       cin0_i,
   input  logic       sub_i,
   output logic [1:0] sum_o,
   output logic       c1_o
);

   logic [1:0] bx;
   logic       c0;

   assign bx = b_i ^ {2{sub_i}};

   assign sum_o[0] = a_i[0] ^ bx[0] ^ cin0_i;
   assign c0       = (a_i[0] & bx[0]) | (cin0_i & (a_i[0] ^ bx[0]));

   assign sum_o[1] = a_i[1] ^ bx[1] ^ c0;
   assign c1_o     = (a_i[1] & bx[1]) | (c0 & (a_i[1] ^ bx[1]));

endmodule

// File: rtl/digit_serial_addsub.sv
// Sequencer feeding WIDTH-bit operands through a 2-bit slice, LSB digit
// first, with a registered carry linking digits; valid/ready on both sides.
module digit_serial_addsub
   import digit_serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam int NDIG  = WIDTH / DIGIT_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

   if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_width_chk
      $error("digit_serial_addsub: WIDTH must be even and >= 2");
   end

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             msb_a_q, msb_a_d;
   logic             msb_b_q, msb_b_d;

   logic [1:0]       dsum;
   logic             dc1;
   logic [WIDTH-1:0] sum_ext;
   logic [WIDTH-1:0] res_shift;

   // Inversion for subtract is applied at accept, so the slice only adds.
   twoBitAdder u_slice (
      .a_i    (a_q[1:0]),
      .b_i    (b_q[1:0]),
      .cin0_i (carry_q),
      .sub_i  (1'b0),
      .sum_o  (dsum),
      .c1_o   (dc1)
   );

   always_comb begin
      sum_ext = '0;
      sum_ext[DIGIT_W-1:0] = dsum;
      res_shift = (res_q >> DIGIT_W) | (sum_ext << (WIDTH - DIGIT_W));
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      res_d   = res_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      msb_a_d = msb_a_q;
      msb_b_d = msb_b_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = op_b ^ {WIDTH{op_sub}};
               msb_a_d = op_a[WIDTH-1];
               msb_b_d = op_b[WIDTH-1] ^ op_sub;
               carry_d = op_sub;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_d     = a_q >> DIGIT_W;
            b_d     = b_q >> DIGIT_W;
            res_d   = res_shift;
            carry_d = dc1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cout_d  = dc1;
               ovf_d   = (msb_a_q == msb_b_q) &&
                         (res_shift[WIDTH-1] != msb_a_q);
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         msb_a_q <= 1'b0;
         msb_b_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         msb_a_q <= msb_a_d;
         msb_b_q <= msb_b_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = res_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Scoreboard bench for digit_serial_addsub at WIDTH=8.
// Directed vectors; a negedge monitor pops expectations on each handshake.
module tb_digit_serial_addsub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         op_sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   typedef struct packed {
      logic [W-1:0] res;
      logic         c;
      logic         o;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc = -100;
   logic prev_v = 1'b0;

   digit_serial_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   // Monitor: latency of out_valid rise and scoreboard pop on handshake.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_v = 1'b0;
      end else begin
         if (in_valid && in_ready) acc = cyc;
         if (out_valid && !prev_v)
            check("latency", cyc - (acc + 1), 4);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output got %0h want none", result);
            end else begin
               e = sb.pop_front();
               check("result", {24'd0, result}, {24'd0, e.res});
               check("carry_out", {31'd0, carry_out}, {31'd0, e.c});
               check("overflow", {31'd0, overflow}, {31'd0, e.o});
            end
         end
         prev_v = out_valid;
      end
   end

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic push, input exp_t e);
      int n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout got 0 want 1");
      end
      if (push) sb.push_back(e);
      op_a = a;
      op_b = b;
      op_sub = s;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout got %0d want 0", sb.size());
         sb.delete();
      end
   endtask

   logic [W-1:0] va [4] = '{8'h5A, 8'hFF, 8'h10, 8'h80};
   logic [W-1:0] vb [4] = '{8'h33, 8'h01, 8'h20, 8'h01};
   logic         vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   logic [W-1:0] vr [4] = '{8'h8D, 8'h00, 8'hF0, 8'h7F};
   logic         vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic         vo [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      int n;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 1);
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_result", {24'd0, result}, 0);
      check("rst_carry", {31'd0, carry_out}, 0);
      check("rst_ovf", {31'd0, overflow}, 0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      // Directed add/sub vectors
      for (int i = 0; i < 4; i++) begin
         do_op(va[i], vb[i], vs[i], 1'b1, '{res: vr[i], c: vc[i], o: vo[i]});
         drain();
      end

      // Backpressure: hold DONE three cycles, ignore in_valid
      out_ready = 1'b0;
      do_op(8'h12, 8'h34, 1'b0, 1'b1, '{res: 8'h46, c: 1'b0, o: 1'b0});
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_valid", {31'd0, out_valid}, 1);
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         op_a = 8'hFF;
         op_b = 8'hFF;
         check("bp_hold_result", {24'd0, result}, 32'h46);
         check("bp_hold_valid", {31'd0, out_valid}, 1);
         check("bp_in_ready", {31'd0, in_ready}, 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_in_ready_after", {31'd0, in_ready}, 1);
      check("bp_out_valid_after", {31'd0, out_valid}, 0);
      check("bp_result_kept", {24'd0, result}, 32'h46);
      drain();

      // Reset during the second RUN cycle discards the operation
      do_op(8'h33, 8'h44, 1'b0, 1'b0, '0);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("mid_rst_in_ready", {31'd0, in_ready}, 1);
      check("mid_rst_out_valid", {31'd0, out_valid}, 0);
      check("mid_rst_result", {24'd0, result}, 0);
      @(negedge clk) reset = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("mid_rst_no_pulse", {31'd0, out_valid}, 0);
      do_op(8'h01, 8'h01, 1'b0, 1'b1, '{res: 8'h02, c: 1'b0, o: 1'b0});
      drain();

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
